// File: rtl/input_conditioner_if.sv
// Bundles the raw input, glitch-clear control and all conditioned outputs of input_conditioner.
// The conditioner owns the slave side; whatever drives the raw input owns the master side.
interface input_conditioner_if #(
    parameter int GLITCH_W = 8
);
    logic                d_in;
    logic                clr_glitch;
    logic                level_out;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_cnt;

    modport master (
        output d_in,
        output clr_glitch,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  d_in,
        input  clr_glitch,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes and debounces an asynchronous input, producing a clean level,
// one-cycle edge strobes and a saturating count of rejected glitches.
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input logic                clk,
    input logic                rstn,
    input_conditioner_if.slave cond
);
    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_e;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("input_conditioner: SYNC_STAGES must be within 2..4");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be within 1..2^CNT_W-1");
    end

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 busy_q, busy_d;
    logic [GLITCH_W-1:0]  glitch_q, glitch_d;
    logic                 syncIn;
    logic                 glitchHit;

    assign syncIn = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cond.d_in};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE_LOW;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    // A candidate level must hold for DEBOUNCE_CYCLES samples; any reversion counts as a glitch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        glitchHit = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (syncIn) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!syncIn) begin
                    state_d   = IDLE_LOW;
                    glitchHit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!syncIn) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (syncIn) begin
                    state_d   = IDLE_HIGH;
                    glitchHit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE_LOW;
            end
        endcase

        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);

        // Clear takes priority over a coincident glitch.
        if (cond.clr_glitch) begin
            glitch_d = '0;
        end else if (glitchHit && (glitch_q != GLITCH_MAX)) begin
            glitch_d = glitch_q + 1'b1;
        end else begin
            glitch_d = glitch_q;
        end
    end

    assign cond.level_out  = level_q;
    assign cond.rise_pulse = rise_q;
    assign cond.fall_pulse = fall_q;
    assign cond.busy       = busy_q;
    assign cond.glitch_cnt = glitch_q;
endmodule
